// File: rtl/mux_scan_serializer.sv
// Parallel-to-serial scanner: captures a 2**SEL_W-bit word and walks a select
// index across it one bit per clock, exporting the index for an external MUX.
module mux_scan_serializer #(
   parameter int unsigned SEL_W     = 3,
   parameter bit          MSB_FIRST = 1'b0
) (
   input  logic                     Clock,
   input  logic                     Resetn,
   input  logic                     Start,
   input  logic [(1<<SEL_W)-1:0]    Data,
   input  logic                     Hold,
   output logic [SEL_W-1:0]         Sel,
   output logic                     SerOut,
   output logic                     Valid,
   output logic                     Busy,
   output logic                     Done
);

   localparam int unsigned N = 1 << SEL_W;
   localparam logic [SEL_W-1:0] FIRST_IDX = MSB_FIRST ? SEL_W'(N - 1) : '0;
   localparam logic [SEL_W-1:0] LAST_IDX  = MSB_FIRST ? '0 : SEL_W'(N - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SEND = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t         state;
   logic [N-1:0]   word;
   logic [N-1:0]   dec;

   // Scan FSM; Valid/Busy/Done are registered alongside the state.
   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         state <= ST_IDLE;
         Sel   <= FIRST_IDX;
         word  <= '0;
         Valid <= 1'b0;
         Busy  <= 1'b0;
         Done  <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (Start) begin
                  state <= ST_SEND;
                  word  <= Data;
                  Sel   <= FIRST_IDX;
                  Valid <= 1'b1;
                  Busy  <= 1'b1;
               end
            end
            ST_SEND: begin
               if (!Hold) begin
                  if (Sel == LAST_IDX) begin
                     state <= ST_DONE;
                     Sel   <= FIRST_IDX;
                     Valid <= 1'b0;
                     Done  <= 1'b1;
                  end else if (MSB_FIRST) begin
                     Sel <= Sel - SEL_W'(1);
                  end else begin
                     Sel <= Sel + SEL_W'(1);
                  end
               end
            end
            ST_DONE: begin
               state <= ST_IDLE;
               Done  <= 1'b0;
               Busy  <= 1'b0;
            end
            default: begin
               state <= ST_IDLE;
               Sel   <= FIRST_IDX;
               Valid <= 1'b0;
               Busy  <= 1'b0;
               Done  <= 1'b0;
            end
         endcase
      end
   end

   // One-hot decode of the registered index; AND-OR selects the bit.
   always_comb begin
      dec      = '0;
      dec[Sel] = 1'b1;
   end

   assign SerOut = Valid & (|(dec & word));

endmodule

// File: tb/tb_mux_scan_serializer.sv
// Directed bench for mux_scan_serializer: vector table for the LSB-first
// instance plus hand-written sequences for MSB-first and mid-word reset.
module tb_mux_scan_serializer;

   logic       Clock = 1'b0;
   logic       clk_en = 1'b0;
   logic       Resetn;
   logic       Start;
   logic [7:0] Data;
   logic       Hold;

   logic [2:0] sel_l, sel_m;
   logic       ser_l, ser_m, valid_l, valid_m, busy_l, busy_m, done_l, done_m;

   int n_pass = 0;
   int n_total = 0;

   mux_scan_serializer #(.SEL_W(3), .MSB_FIRST(1'b0)) dut_lsb (
      .Clock(Clock), .Resetn(Resetn), .Start(Start), .Data(Data), .Hold(Hold),
      .Sel(sel_l), .SerOut(ser_l), .Valid(valid_l), .Busy(busy_l), .Done(done_l)
   );

   mux_scan_serializer #(.SEL_W(3), .MSB_FIRST(1'b1)) dut_msb (
      .Clock(Clock), .Resetn(Resetn), .Start(Start), .Data(Data), .Hold(Hold),
      .Sel(sel_m), .SerOut(ser_m), .Valid(valid_m), .Busy(busy_m), .Done(done_m)
   );

   always begin
      #5;
      if (clk_en) Clock = ~Clock;
   end

   typedef struct {
      logic       start;
      logic [7:0] data;
      logic       hold;
      logic [2:0] sel;
      logic       ser;
      logic       valid;
      logic       busy;
      logic       done;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(input logic st, input logic [7:0] d, input logic h,
                               input logic [2:0] s, input logic so, input logic v,
                               input logic b, input logic dn);
      vec_t r;
      r.start = st; r.data = d; r.hold = h;
      r.sel = s; r.ser = so; r.valid = v; r.busy = b; r.done = dn;
      return r;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
   endtask

   task automatic chk_l(input string tag, input logic [2:0] s, input logic so,
                        input logic v, input logic b, input logic dn);
      chk({tag, ".sel"},   32'(sel_l),   32'(s));
      chk({tag, ".ser"},   32'(ser_l),   32'(so));
      chk({tag, ".valid"}, 32'(valid_l), 32'(v));
      chk({tag, ".busy"},  32'(busy_l),  32'(b));
      chk({tag, ".done"},  32'(done_l),  32'(dn));
   endtask

   task automatic chk_m(input string tag, input logic [2:0] s, input logic so,
                        input logic v, input logic b, input logic dn);
      chk({tag, ".msb_sel"},   32'(sel_m),   32'(s));
      chk({tag, ".msb_ser"},   32'(ser_m),   32'(so));
      chk({tag, ".msb_valid"}, 32'(valid_m), 32'(v));
      chk({tag, ".msb_busy"},  32'(busy_m),  32'(b));
      chk({tag, ".msb_done"},  32'(done_m),  32'(dn));
   endtask

   task automatic tick;
      @(posedge Clock);
      #1;
   endtask

   initial begin
      logic [7:0] a5;
      logic [7:0] w6;
      logic [7:0] b2;
      logic [7:0] f0;

      b2 = 8'b1011_0010;
      f0 = 8'hF0;

      // LSB-first word 0xB2
      tbl.push_back(mk(1'b1, b2, 1'b0, 3'd0, 1'b0, 1'b1, 1'b1, 1'b0));
      for (int i = 1; i < 8; i++)
         tbl.push_back(mk(1'b0, 8'h00, 1'b0, 3'(i), b2[i], 1'b1, 1'b1, 1'b0));
      tbl.push_back(mk(1'b0, 8'h00, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b1));
      tbl.push_back(mk(1'b0, 8'h00, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0));
      // Hold in IDLE has no effect
      tbl.push_back(mk(1'b0, 8'h00, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0));

      // Word 0xF0 with Hold for 3 cycles at Sel=4
      tbl.push_back(mk(1'b1, f0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b1, 1'b0));
      for (int i = 1; i <= 4; i++)
         tbl.push_back(mk(1'b0, 8'h00, 1'b0, 3'(i), f0[i], 1'b1, 1'b1, 1'b0));
      for (int i = 0; i < 3; i++)
         tbl.push_back(mk(1'b0, 8'h00, 1'b1, 3'd4, 1'b1, 1'b1, 1'b1, 1'b0));
      for (int i = 5; i < 8; i++)
         tbl.push_back(mk(1'b0, 8'h00, 1'b0, 3'(i), 1'b1, 1'b1, 1'b1, 1'b0));
      tbl.push_back(mk(1'b0, 8'h00, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b1));
      tbl.push_back(mk(1'b0, 8'h00, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0));

      // Word 0x00 with Start=1/Data=0xFF held through SEND and DONE
      tbl.push_back(mk(1'b1, 8'h00, 1'b0, 3'd0, 1'b0, 1'b1, 1'b1, 1'b0));
      for (int i = 1; i < 8; i++)
         tbl.push_back(mk(1'b1, 8'hFF, 1'b0, 3'(i), 1'b0, 1'b1, 1'b1, 1'b0));
      tbl.push_back(mk(1'b1, 8'hFF, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b1));
      tbl.push_back(mk(1'b1, 8'hFF, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0));
      // Next word only accepted from IDLE; Data changes afterwards are ignored
      tbl.push_back(mk(1'b1, 8'hFF, 1'b0, 3'd0, 1'b1, 1'b1, 1'b1, 1'b0));
      for (int i = 1; i < 8; i++)
         tbl.push_back(mk(1'b0, 8'h00, 1'b0, 3'(i), 1'b1, 1'b1, 1'b1, 1'b0));
      // Hold on the last bit delays DONE
      for (int i = 0; i < 2; i++)
         tbl.push_back(mk(1'b0, 8'h00, 1'b1, 3'd7, 1'b1, 1'b1, 1'b1, 1'b0));
      tbl.push_back(mk(1'b0, 8'h00, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b1));
      tbl.push_back(mk(1'b0, 8'h00, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0));

      // Reset with the clock stopped
      Start = 1'b0; Data = 8'h00; Hold = 1'b0;
      Resetn = 1'b1;
      #2;
      Resetn = 1'b0;
      #1;
      chk_l("reset", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk_m("reset", 3'd7, 1'b0, 1'b0, 1'b0, 1'b0);

      clk_en = 1'b1;
      tick();
      Resetn = 1'b1;
      tick();
      tick();
      chk_l("idle", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);

      for (int k = 0; k < tbl.size(); k++) begin
         Start = tbl[k].start;
         Data  = tbl[k].data;
         Hold  = tbl[k].hold;
         tick();
         chk_l($sformatf("vec%0d", k), tbl[k].sel, tbl[k].ser, tbl[k].valid,
               tbl[k].busy, tbl[k].done);
      end
      Start = 1'b0; Data = 8'h00; Hold = 1'b0;

      // MSB-first word 0xA5
      a5 = 8'hA5;
      Start = 1'b1; Data = a5;
      tick();
      Start = 1'b0; Data = 8'h00;
      for (int i = 7; i >= 0; i--) begin
         chk_m($sformatf("msb_bit%0d", i), 3'(i), a5[i], 1'b1, 1'b1, 1'b0);
         tick();
      end
      chk_m("msb_done", 3'd7, 1'b0, 1'b0, 1'b1, 1'b1);
      tick();
      chk_m("msb_idle", 3'd7, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();

      // Mid-word asynchronous reset at Sel=5, then a full word from Sel=0
      w6 = 8'h5A;
      Start = 1'b1; Data = w6;
      tick();
      Start = 1'b0; Data = 8'h00;
      for (int i = 0; i < 5; i++) tick();
      chk("pre_rst.sel", 32'(sel_l), 32'd5);
      #2;
      Resetn = 1'b0;
      #1;
      chk_l("mid_rst", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      Resetn = 1'b1;
      Start = 1'b1; Data = w6;
      tick();
      Start = 1'b0; Data = 8'h00;
      for (int i = 0; i < 8; i++) begin
         chk_l($sformatf("post_rst_bit%0d", i), 3'(i), w6[i], 1'b1, 1'b1, 1'b0);
         tick();
      end
      chk_l("post_rst_done", 3'd0, 1'b0, 1'b0, 1'b1, 1'b1);
      tick();
      chk_l("post_rst_idle", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
